// File: rtl/frame_cfg_shadow_pkg.sv
// Shared definitions for the frame configuration shadow bank: FSM states,
// config field indices and default geometry.
package frame_cfg_pkg;

    localparam int DEF_NUM_FIELDS  = 4;
    localparam int DEF_FIELD_W     = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Field slots within the packed config word, lowest slot at bit 0
    localparam int FLD_SOURCE       = 0;
    localparam int FLD_FRAMEDAT_LEN = 1;
    localparam int FLD_TRACE_LEN    = 2;
    localparam int FLD_RETRACE_LEN  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/frame_cfg_shadow_if.sv
// Host-side update request and frame-generator config bus of the shadow bank.
// Optional per-field write mask exists only when FRAME_CFG_MASK_EN is defined.
interface frame_cfg_shadow_if
    import frame_cfg_pkg::*;
#(
    parameter int NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int FIELD_W    = DEF_FIELD_W
);

    logic                          update_flag;
    logic [NUM_FIELDS*FIELD_W-1:0] cfg_in;
    logic                          apply_mode;
    logic                          frame_start;
    logic                          err_clr;
`ifdef FRAME_CFG_MASK_EN
    logic [NUM_FIELDS-1:0]         field_mask;
`endif
    logic [NUM_FIELDS*FIELD_W-1:0] cfg_out;
    logic                          cfg_valid;
    logic                          update_pending;
    logic                          update_done;
    logic                          overrun_err;

    modport master (
        output update_flag, cfg_in, apply_mode, frame_start, err_clr,
`ifdef FRAME_CFG_MASK_EN
        output field_mask,
`endif
        input  cfg_out, cfg_valid, update_pending, update_done, overrun_err
    );

    modport slave (
        input  update_flag, cfg_in, apply_mode, frame_start, err_clr,
`ifdef FRAME_CFG_MASK_EN
        input  field_mask,
`endif
        output cfg_out, cfg_valid, update_pending, update_done, overrun_err
    );

endinterface

// File: rtl/frame_cfg_shadow_sync.sv
// Brings the foreign-domain update level into clk and emits a one-cycle req per rising edge.
// SYNC_STAGES (2..4) flops then one history flop; a level held high yields a single req.
module cfg_req_sync
    import frame_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flag_i,
    output logic req_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], flag_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign req_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/frame_cfg_shadow.sv
// Frame configuration shadow bank: applies a requested config now or at the next frame_start.
// Build option FRAME_CFG_MASK_EN adds a per-field write mask on the interface.
module frame_cfg_shadow
    import frame_cfg_pkg::*;
#(
    parameter int NUM_FIELDS  = DEF_NUM_FIELDS,
    parameter int FIELD_W     = DEF_FIELD_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               reset_n,
    frame_cfg_shadow_if.slave  bus
);

    localparam int CFG_W = NUM_FIELDS * FIELD_W;

    logic             req;
    state_t           state_q;
    logic [CFG_W-1:0] cfg_out_q;
    logic [CFG_W-1:0] staging_q;
    logic [CFG_W-1:0] cfg_merged;
    logic             done_q;
    logic             valid_q;
    logic             err_q;

    cfg_req_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .flag_i  (bus.update_flag),
        .req_o   (req)
    );

    // Masked-off fields fall back to the live output, so staging holds a complete image
    always_comb begin
        cfg_merged = bus.cfg_in;
`ifdef FRAME_CFG_MASK_EN
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!bus.field_mask[i]) begin
                cfg_merged[i*FIELD_W +: FIELD_W] = cfg_out_q[i*FIELD_W +: FIELD_W];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cfg_out_q <= '0;
            staging_q <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (!bus.apply_mode) begin
                            cfg_out_q <= cfg_merged;
                            done_q    <= 1'b1;
                            valid_q   <= 1'b1;
                        end else begin
                            staging_q <= cfg_merged;
                            state_q   <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (req) begin
                        // A second request before the boundary is an overrun; newest config wins
                        err_q <= 1'b1;
                        if (bus.frame_start) begin
                            cfg_out_q <= cfg_merged;
                            done_q    <= 1'b1;
                            valid_q   <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            staging_q <= cfg_merged;
                        end
                    end else if (bus.frame_start) begin
                        cfg_out_q <= staging_q;
                        done_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cfg_out        = cfg_out_q;
    assign bus.cfg_valid      = valid_q;
    assign bus.update_pending = (state_q == PENDING);
    assign bus.update_done    = done_q;
    assign bus.overrun_err    = err_q;

endmodule

// File: tb/tb_frame_cfg_shadow.sv
// Bench for frame_cfg_shadow: directed scenarios plus randomized request/frame traffic
// against a transaction-level model of the active, staged and error state.
`timescale 1ns/1ps
module tb_frame_cfg_shadow;
    import frame_cfg_pkg::*;

    localparam int NF = 4;
    localparam int FW = 16;
    localparam int SS = 2;
    localparam int CW = NF * FW;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    frame_cfg_shadow_if #(.NUM_FIELDS(NF), .FIELD_W(FW)) bus ();

    frame_cfg_shadow #(
        .NUM_FIELDS  (NF),
        .FIELD_W     (FW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: what the frame generator should see, what is parked, and error/valid flags
    logic [CW-1:0] m_cfg   = '0;
    logic [CW-1:0] m_stage = '0;
    bit            m_pend  = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_err   = 1'b0;
    logic [NF-1:0] mask_v  = '1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] merge(input logic [NF-1:0] m, input logic [CW-1:0] nv,
                                            input logic [CW-1:0] ov);
        logic [CW-1:0] r;
        for (int i = 0; i < NF; i++) r[i*FW +: FW] = m[i] ? nv[i*FW +: FW] : ov[i*FW +: FW];
        return r;
    endfunction

    function automatic logic [CW-1:0] rnd_cfg();
        return {$urandom, $urandom};
    endfunction

    task automatic model_req(input logic [CW-1:0] nv, input bit mode, input bit fs,
                             input bit clr, output bit done);
        logic [CW-1:0] eff;
        eff  = merge(mask_v, nv, m_cfg);
        done = 1'b0;
        if (clr) m_err = 1'b0;
        if (!m_pend) begin
            if (!mode) begin
                m_cfg = eff; done = 1'b1; m_valid = 1'b1;
            end else begin
                m_stage = eff; m_pend = 1'b1;
            end
        end else begin
            m_err = 1'b1;
            if (fs) begin
                m_cfg = eff; m_pend = 1'b0; done = 1'b1; m_valid = 1'b1;
            end else begin
                m_stage = eff;
            end
        end
    endtask

    task automatic model_fs(input bit clr, output bit done);
        done = 1'b0;
        if (clr) m_err = 1'b0;
        if (m_pend) begin
            m_cfg = m_stage; m_pend = 1'b0; done = 1'b1; m_valid = 1'b1;
        end
    endtask

    task automatic drive_mask(input logic [NF-1:0] m);
        mask_v = m;
`ifdef FRAME_CFG_MASK_EN
        bus.field_mask = m;
`endif
    endtask

    // Raise the request and stop just before the edge where it takes effect
    task automatic start_req(input logic [CW-1:0] nv, input bit mode);
        bus.cfg_in      = nv;
        bus.apply_mode  = mode;
        bus.update_flag = 1'b1;
        repeat (SS) tick();
    endtask

    task automatic end_req();
        bus.update_flag = 1'b0;
        bus.frame_start = 1'b0;
        bus.err_clr     = 1'b0;
        repeat (SS + 1) tick();
    endtask

    task automatic test_reset();
        bus.update_flag = 1'b0; bus.cfg_in = '0; bus.apply_mode = 1'b0;
        bus.frame_start = 1'b0; bus.err_clr = 1'b0;
        drive_mask('1);
        reset_n = 1'b0;
        tick(); tick();
        total++;
        if (bus.cfg_out !== '0) begin bad++; $display("FAIL reset_cfg: got %h want 0", bus.cfg_out); end
        total++;
        if ({bus.cfg_valid, bus.update_pending, bus.update_done, bus.overrun_err} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000",
                {bus.cfg_valid, bus.update_pending, bus.update_done, bus.overrun_err});
        end
        reset_n = 1'b1;
        tick(); tick();
        total++;
        if ({bus.cfg_valid, bus.update_pending, bus.update_done} !== 3'b000) begin
            bad++; $display("FAIL reset_release: got %b want 000",
                {bus.cfg_valid, bus.update_pending, bus.update_done});
        end
    endtask

    task automatic test_immediate();
        logic [CW-1:0] v;
        v = {16'd300, 16'd40, 16'd1024, 16'd5};
        bus.cfg_in = v; bus.apply_mode = 1'b0; bus.update_flag = 1'b1;
        for (int c = 0; c < SS; c++) begin
            tick();
            total++;
            if (bus.update_done !== 1'b0 || bus.cfg_out !== m_cfg) begin
                bad++; $display("FAIL imm_early: cycle %0d done=%b cfg=%h want done=0 cfg=%h",
                    c, bus.update_done, bus.cfg_out, m_cfg);
            end
        end
        tick();
        m_cfg = v; m_valid = 1'b1;
        total++;
        if (bus.cfg_out !== v) begin bad++; $display("FAIL imm_cfg: got %h want %h", bus.cfg_out, v); end
        total++;
        if (bus.update_done !== 1'b1) begin bad++; $display("FAIL imm_done: got %b want 1", bus.update_done); end
        total++;
        if (bus.cfg_valid !== 1'b1) begin bad++; $display("FAIL imm_valid: got %b want 1", bus.cfg_valid); end
        tick();
        total++;
        if (bus.update_done !== 1'b0) begin bad++; $display("FAIL imm_done_pulse: got %b want 0", bus.update_done); end
        end_req();
    endtask

    task automatic test_deferred();
        logic [CW-1:0] v, old;
        int held_bad;
        old = m_cfg; v = rnd_cfg(); held_bad = 0;
        start_req(v, 1'b1);
        tick();
        total++;
        if (bus.update_pending !== 1'b1 || bus.update_done !== 1'b0) begin
            bad++; $display("FAIL def_stage: pend=%b done=%b want 1 0", bus.update_pending, bus.update_done);
        end
        end_req();
        repeat (14) begin
            tick();
            if (bus.update_pending !== 1'b1 || bus.cfg_out !== old) held_bad++;
        end
        total++;
        if (held_bad !== 0) begin bad++; $display("FAIL def_hold: got %0d bad cycles want 0", held_bad); end
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        m_cfg = v;
        total++;
        if (bus.cfg_out !== v) begin bad++; $display("FAIL def_cfg: got %h want %h", bus.cfg_out, v); end
        total++;
        if (bus.update_done !== 1'b1 || bus.update_pending !== 1'b0) begin
            bad++; $display("FAIL def_flags: done=%b pend=%b want 1 0", bus.update_done, bus.update_pending);
        end
        tick();
    endtask

    task automatic test_overrun();
        logic [CW-1:0] a, b, old;
        old = m_cfg; a = rnd_cfg(); b = a;
        b[FLD_TRACE_LEN*FW +: FW] = 16'd2048;
        start_req(a, 1'b1); tick(); end_req();
        start_req(b, 1'b1); tick();
        total++;
        if (bus.overrun_err !== 1'b1 || bus.update_pending !== 1'b1) begin
            bad++; $display("FAIL ovr_flag: err=%b pend=%b want 1 1", bus.overrun_err, bus.update_pending);
        end
        total++;
        if (bus.cfg_out !== old) begin bad++; $display("FAIL ovr_hold: got %h want %h", bus.cfg_out, old); end
        end_req();
        bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
        m_cfg = b;
        total++;
        if (bus.cfg_out !== b || bus.update_done !== 1'b1) begin
            bad++; $display("FAIL ovr_apply: got %h done=%b want %h done=1", bus.cfg_out, bus.update_done, b);
        end
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
        total++;
        if (bus.overrun_err !== 1'b0) begin bad++; $display("FAIL ovr_clr: got %b want 0", bus.overrun_err); end
    endtask

    task automatic test_collision();
        logic [CW-1:0] a, b;
        a = rnd_cfg(); b = rnd_cfg();
        start_req(a, 1'b1); tick(); end_req();
        start_req(b, 1'b0);
        bus.frame_start = 1'b1; bus.err_clr = 1'b1;
        tick();
        m_cfg = b;
        total++;
        if (bus.cfg_out !== b) begin bad++; $display("FAIL col_cfg: got %h want %h", bus.cfg_out, b); end
        total++;
        if ({bus.overrun_err, bus.update_pending, bus.update_done} !== 3'b101) begin
            bad++; $display("FAIL col_flags: got %b want 101",
                {bus.overrun_err, bus.update_pending, bus.update_done});
        end
        end_req();
        bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    endtask

    task automatic test_reset_pending();
        int dones;
        dones = 0;
        start_req(rnd_cfg(), 1'b1); tick(); end_req();
        total++;
        if (bus.update_pending !== 1'b1) begin bad++; $display("FAIL rstp_pre: pend=%b want 1", bus.update_pending); end
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.cfg_out, bus.cfg_valid, bus.update_pending, bus.update_done, bus.overrun_err} !== '0) begin
            bad++; $display("FAIL rstp_async: cfg=%h valid=%b pend=%b want all 0",
                bus.cfg_out, bus.cfg_valid, bus.update_pending);
        end
        tick();
        reset_n = 1'b1;
        m_cfg = '0; m_stage = '0; m_pend = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        tick();
        bus.frame_start = 1'b1;
        repeat (4) begin
            tick();
            bus.frame_start = 1'b0;
            if (bus.update_done === 1'b1) dones++;
        end
        total++;
        if (dones !== 0 || bus.cfg_out !== '0 || bus.update_pending !== 1'b0) begin
            bad++; $display("FAIL rstp_after: dones=%0d cfg=%h pend=%b want 0 0 0",
                dones, bus.cfg_out, bus.update_pending);
        end
    endtask

    task automatic test_held_level();
        logic [CW-1:0] v;
        int dones;
        v = rnd_cfg(); dones = 0;
        bus.cfg_in = v; bus.apply_mode = 1'b0; bus.update_flag = 1'b1;
        repeat (100) begin
            tick();
            if (bus.update_done === 1'b1) dones++;
        end
        m_cfg = v; m_valid = 1'b1;
        total++;
        if (dones !== 1) begin bad++; $display("FAIL held_count: got %0d want 1", dones); end
        total++;
        if (bus.cfg_out !== v || bus.cfg_valid !== 1'b1) begin
            bad++; $display("FAIL held_cfg: got %h valid=%b want %h 1", bus.cfg_out, bus.cfg_valid, v);
        end
        end_req();
    endtask

`ifdef FRAME_CFG_MASK_EN
    task automatic test_mask();
        logic [CW-1:0] v, exp_v;
        v = rnd_cfg();
        exp_v = m_cfg;
        exp_v[FLD_TRACE_LEN*FW +: FW] = v[FLD_TRACE_LEN*FW +: FW];
        drive_mask(4'b0100);
        start_req(v, 1'b0); tick();
        m_cfg = exp_v;
        total++;
        if (bus.cfg_out !== exp_v) begin bad++; $display("FAIL mask_cfg: got %h want %h", bus.cfg_out, exp_v); end
        end_req();
        drive_mask('1);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit fs, clr, mode, exp_done;
            logic [CW-1:0] nv;
            fs  = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
`ifdef FRAME_CFG_MASK_EN
            drive_mask(NF'($urandom));
`endif
            if ($urandom_range(0, 3) != 0) begin
                nv = rnd_cfg(); mode = 1'($urandom_range(0, 1));
                start_req(nv, mode);
                bus.frame_start = fs; bus.err_clr = clr;
                model_req(nv, mode, fs, clr, exp_done);
            end else begin
                bus.frame_start = 1'b1; bus.err_clr = clr;
                model_fs(clr, exp_done);
            end
            tick();
            total++;
            if (bus.cfg_out !== m_cfg) begin bad++; $display("FAIL rnd_cfg: op %0d got %h want %h", n, bus.cfg_out, m_cfg); end
            total++;
            if (bus.update_done !== exp_done) begin bad++; $display("FAIL rnd_done: op %0d got %b want %b", n, bus.update_done, exp_done); end
            total++;
            if (bus.update_pending !== m_pend) begin bad++; $display("FAIL rnd_pend: op %0d got %b want %b", n, bus.update_pending, m_pend); end
            total++;
            if (bus.cfg_valid !== m_valid) begin bad++; $display("FAIL rnd_valid: op %0d got %b want %b", n, bus.cfg_valid, m_valid); end
            total++;
            if (bus.overrun_err !== m_err) begin bad++; $display("FAIL rnd_err: op %0d got %b want %b", n, bus.overrun_err, m_err); end
            end_req();
        end
        drive_mask('1);
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_deferred();
        test_overrun();
        test_collision();
        test_reset_pending();
        test_held_level();
`ifdef FRAME_CFG_MASK_EN
        test_mask();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
